fp_mul_seq: RTL

Sequential IEEE-754 floating-point multiplier, the multiply-side counterpart to the divider instance used in the arithmetic datapath. It computes z = a × b with a shift-add significand multiply, one multiplier bit per cycle, and has a fixed latency. Rounding and status semantics follow the divider's `ieee_compliance = 0` conventions, so the two blocks can share operand/result buses and status decoding. A start/done handshake lets the contest top-level FSM time-multiplex it.

---
 rtl/fp_mul_pkg.sv | 20 ++
 rtl/fp_mul_round.sv | 91 +++++++++
 rtl/fp_mul_seq.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/fp_mul_pkg.sv
// Shared types and constants for the sequential floating-point multiplier.
package fp_mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    RND  = 2'd2
  } state_t;

  localparam int ST_ZERO    = 0;
  localparam int ST_INF     = 1;
  localparam int ST_INVALID = 2;
  localparam int ST_TINY    = 3;
  localparam int ST_HUGE    = 4;
  localparam int ST_INEXACT = 5;

  localparam logic [2:0] RND_NE   = 3'd0;
  localparam logic [2:0] RND_ZERO = 3'd1;

endpackage

// File: rtl/fp_mul_round.sv
// Normalize, round and pack a raw significand product into an IEEE-754 word plus status.
// Special-operand flags override the arithmetic result; denormals are flushed to zero.
module fp_mul_round
  import fp_mul_pkg::*;
#(
  parameter int sig_width = 23,
  parameter int exp_width = 8
) (
  input  logic [2*sig_width+1:0]       prod,
  input  logic signed [exp_width+1:0]  exp_sum,
  input  logic                         sign,
  input  logic [2:0]                   rnd,
  input  logic                         sp_zero,
  input  logic                         sp_inf,
  input  logic                         sp_invalid,
  output logic [sig_width+exp_width:0] z,
  output logic [7:0]                   status
);

  localparam int PW  = 2*sig_width+2;
  localparam int EW2 = exp_width+2;
  localparam logic signed [EW2-1:0] EXP_ONE  = signed'(EW2'(1));
  localparam logic signed [EW2-1:0] EXP_ZERO = signed'(EW2'(0));
  localparam logic signed [EW2-1:0] EXP_MAX  = signed'({2'b00, {exp_width{1'b1}}});
  localparam logic [exp_width-1:0]  EXP_ONES = {exp_width{1'b1}};

  logic [sig_width-1:0]    frac_s;
  logic [sig_width-1:0]    frac_out_s;
  logic                    guard_s;
  logic                    sticky_s;
  logic                    round_up_s;
  logic [sig_width+1:0]    sig_rnd_s;
  logic signed [EW2-1:0]   exp_s;
  logic signed [EW2-1:0]   exp_fin_s;

  // Normalize the product, pick the round increment and renormalize on carry-out.
  always_comb begin
    if (prod[PW-1]) begin
      frac_s   = prod[PW-2 -: sig_width];
      guard_s  = prod[sig_width];
      sticky_s = |prod[sig_width-1:0];
      exp_s    = exp_sum + EXP_ONE;
    end else begin
      frac_s   = prod[PW-3 -: sig_width];
      guard_s  = prod[sig_width-1];
      sticky_s = |prod[sig_width-2:0];
      exp_s    = exp_sum;
    end
    case (rnd)
      RND_ZERO: round_up_s = 1'b0;
      default:  round_up_s = guard_s & (sticky_s | frac_s[0]);
    endcase
    sig_rnd_s = {2'b01, frac_s} + {{(sig_width+1){1'b0}}, round_up_s};
    if (sig_rnd_s[sig_width+1]) begin
      frac_out_s = sig_rnd_s[sig_width:1];
      exp_fin_s  = exp_s + EXP_ONE;
    end else begin
      frac_out_s = sig_rnd_s[sig_width-1:0];
      exp_fin_s  = exp_s;
    end
  end

  // Select special, overflow, underflow or normal packing and the matching status.
  always_comb begin
    status = 8'h00;
    if (sp_invalid) begin
      z = {1'b0, EXP_ONES, {sig_width{1'b0}}};
      status[ST_INVALID] = 1'b1;
    end else if (sp_inf) begin
      z = {sign, EXP_ONES, {sig_width{1'b0}}};
      status[ST_INF] = 1'b1;
    end else if (sp_zero) begin
      z = {sign, {(exp_width+sig_width){1'b0}}};
      status[ST_ZERO] = 1'b1;
    end else if (exp_fin_s >= EXP_MAX) begin
      z = {sign, EXP_ONES, {sig_width{1'b0}}};
      status[ST_INF]     = 1'b1;
      status[ST_HUGE]    = 1'b1;
      status[ST_INEXACT] = 1'b1;
    end else if (exp_fin_s <= EXP_ZERO) begin
      z = {sign, {(exp_width+sig_width){1'b0}}};
      status[ST_ZERO]    = 1'b1;
      status[ST_TINY]    = 1'b1;
      status[ST_INEXACT] = 1'b1;
    end else begin
      z = {sign, exp_fin_s[exp_width-1:0], frac_out_s};
      status[ST_INEXACT] = guard_s | sticky_s;
    end
  end

endmodule

// File: rtl/fp_mul_seq.sv
// Sequential shift-add IEEE-754 multiplier with fixed latency and a start/done handshake.
// Build option FP_MUL_SEQ_RND_EN honors inst_rnd; without it rounding is always to nearest even.
module fp_mul_seq
  import fp_mul_pkg::*;
#(
  parameter int sig_width = 23,
  parameter int exp_width = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [sig_width+exp_width:0] inst_a,
  input  logic [sig_width+exp_width:0] inst_b,
  input  logic [2:0]                   inst_rnd,
  output logic [sig_width+exp_width:0] z_inst,
  output logic [7:0]                   status_inst,
  output logic                         busy,
  output logic                         done
);

  localparam int PW    = 2*sig_width+2;
  localparam int EW2   = exp_width+2;
  localparam int CNT_W = $clog2(sig_width+1);
  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(sig_width);
  localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1);
  localparam logic [exp_width-1:0]  EXP_ONES = {exp_width{1'b1}};
  localparam logic signed [EW2-1:0] BIAS     = signed'(EW2'((1 << (exp_width-1)) - 1));

  state_t state_r, state_nxt_s;
  logic load_s, step_s, rnd_cyc_s;

  logic                        sign_r;
  logic signed [EW2-1:0]       exp_sum_r, exp_sum_s;
  logic [sig_width:0]          mcand_r, mplier_r;
  logic [PW-1:0]               acc_r, acc_nxt_s;
  logic [sig_width+1:0]        add_s, sum_s;
  logic [CNT_W-1:0]            cnt_r;
  logic                        sp_zero_r, sp_inf_r, sp_invalid_r;
  logic                        a_zero_s, a_inf_s, b_zero_s, b_inf_s;
  logic [exp_width-1:0]        ea_s, eb_s;
  logic [2:0]                  rnd_eff_s;
  logic [sig_width+exp_width:0] z_s, z_r;
  logic [7:0]                  status_s, status_r;
  logic                        busy_r, done_r;

  assign ea_s      = inst_a[sig_width+exp_width-1:sig_width];
  assign eb_s      = inst_b[sig_width+exp_width-1:sig_width];
  assign a_zero_s  = (ea_s == {exp_width{1'b0}});
  assign b_zero_s  = (eb_s == {exp_width{1'b0}});
  assign a_inf_s   = (ea_s == EXP_ONES);
  assign b_inf_s   = (eb_s == EXP_ONES);
  assign exp_sum_s = signed'({2'b00, ea_s}) + signed'({2'b00, eb_s}) - BIAS;

  // One shift-add step: conditionally add the multiplicand into the upper half, then shift right.
  assign add_s     = mplier_r[0] ? {1'b0, mcand_r} : {(sig_width+2){1'b0}};
  assign sum_s     = {1'b0, acc_r[PW-1:sig_width+1]} + add_s;
  assign acc_nxt_s = {sum_s, acc_r[sig_width:1]};

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_r <= IDLE;
    else       state_r <= state_nxt_s;
  end

  // Next-state logic; start outside IDLE is simply not looked at.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE:    if (start) state_nxt_s = MUL; else state_nxt_s = IDLE;
      MUL:     if (cnt_r == CNT_LAST) state_nxt_s = RND; else state_nxt_s = MUL;
      RND:     state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Datapath control strobes decoded from the current state.
  always_comb begin
    load_s    = 1'b0;
    step_s    = 1'b0;
    rnd_cyc_s = 1'b0;
    case (state_r)
      IDLE:    load_s    = start;
      MUL:     step_s    = 1'b1;
      RND:     rnd_cyc_s = 1'b1;
      default: load_s    = 1'b0;
    endcase
  end

  // Operand capture, special-case classification and the multiply iteration.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sign_r       <= 1'b0;
      exp_sum_r    <= '0;
      mcand_r      <= '0;
      mplier_r     <= '0;
      acc_r        <= '0;
      cnt_r        <= '0;
      sp_zero_r    <= 1'b0;
      sp_inf_r     <= 1'b0;
      sp_invalid_r <= 1'b0;
    end else if (load_s) begin
      sign_r       <= inst_a[sig_width+exp_width] ^ inst_b[sig_width+exp_width];
      exp_sum_r    <= exp_sum_s;
      mcand_r      <= {1'b1, inst_a[sig_width-1:0]};
      mplier_r     <= {1'b1, inst_b[sig_width-1:0]};
      acc_r        <= '0;
      cnt_r        <= '0;
      sp_invalid_r <= (a_zero_s & b_inf_s) | (a_inf_s & b_zero_s);
      sp_inf_r     <= a_inf_s | b_inf_s;
      sp_zero_r    <= a_zero_s | b_zero_s;
    end else if (step_s) begin
      acc_r        <= acc_nxt_s;
      mplier_r     <= {1'b0, mplier_r[sig_width:1]};
      cnt_r        <= cnt_r + CNT_ONE;
    end
  end

`ifdef FP_MUL_SEQ_RND_EN
  logic [2:0] rnd_r;

  // Round mode is captured with the operands so later bus changes cannot affect it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       rnd_r <= RND_NE;
    else if (load_s) rnd_r <= inst_rnd;
  end

  assign rnd_eff_s = rnd_r;
`else
  logic [2:0] unused_rnd_s;
  assign unused_rnd_s = inst_rnd;
  assign rnd_eff_s    = RND_NE;
`endif

  fp_mul_round #(
    .sig_width (sig_width),
    .exp_width (exp_width)
  ) u_round (
    .prod       (acc_r),
    .exp_sum    (exp_sum_r),
    .sign       (sign_r),
    .rnd        (rnd_eff_s),
    .sp_zero    (sp_zero_r),
    .sp_inf     (sp_inf_r),
    .sp_invalid (sp_invalid_r),
    .z          (z_s),
    .status     (status_s)
  );

  // Registered result and handshake; the result holds until the next RND cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      z_r      <= '0;
      status_r <= 8'h00;
    end else begin
      busy_r <= (state_nxt_s != IDLE);
      done_r <= rnd_cyc_s;
      if (rnd_cyc_s) begin
        z_r      <= z_s;
        status_r <= status_s;
      end
    end
  end

  assign busy        = busy_r;
  assign done        = done_r;
  assign z_inst      = z_r;
  assign status_inst = status_r;

endmodule
